// File: rtl/cl_sde_pkg.sv
// ---------------------------------------------------------------------------
// cl_sde_pkg
// Shared definitions for the SDE output path:
//   - bus geometry of the SDE output AXI-Stream (data / keep widths)
//   - geometry of one CNN class result
//   - field layout of ots_user
//   - sde_keep_mask(): byte-enable vector for a given number of filled slots
// ---------------------------------------------------------------------------
package cl_sde_pkg;

    localparam int SDE_OTS_W       = 512;
    localparam int SDE_OTS_KEEP_W  = 64;
    localparam int SDE_CLASS_W     = 160;
    localparam int SDE_CLASS_BYTES = 20;

    // ots_user layout, MSB first: [63:32] seq, [31:16] beat, [15:2] rsvd, [1:0] slots
    typedef struct packed {
        logic [31:0] seq;
        logic [15:0] beat;
        logic [13:0] rsvd;
        logic [1:0]  slots;
    } sde_ots_user_t;

    // Low (slots * slot_bytes) bits set; built bit by bit so a full 64-byte
    // beat does not need an out-of-range shift.
    function automatic logic [SDE_OTS_KEEP_W-1:0] sde_keep_mask(
        input int unsigned slots,
        input int unsigned slot_bytes = SDE_CLASS_BYTES
    );
        logic [SDE_OTS_KEEP_W-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < SDE_OTS_KEEP_W; i++) begin
            mask[i] = (i < slots * slot_bytes);
        end
        return mask;
    endfunction

endpackage

// File: rtl/cl_sde_idle_timer.sv
// ---------------------------------------------------------------------------
// cl_sde_idle_timer
// Counts idle cycles while a partially filled staging buffer waits for more
// results. Emits a one-cycle expire pulse in the cycle the count sits at
// IDLE_TO-1 while still enabled; the counter restarts from 0 afterwards.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   en        - count this cycle (partial buffer, nothing accepted)
//   clr       - restart from 0 (result accepted, or buffer empty); wins over en
//   expire    - combinational pulse, count reached IDLE_TO-1 while enabled
// ---------------------------------------------------------------------------
module cl_sde_idle_timer #(
    parameter int IDLE_TO = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expire
);

    localparam logic [15:0] LIMIT = 16'(IDLE_TO - 1);

    logic [15:0] idle;

    assign expire = en && !clr && (idle == LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle <= '0;
        end else if (clr || expire) begin
            idle <= '0;
        end else if (en) begin
            idle <= idle + 16'd1;
        end
    end

endmodule

// File: rtl/cl_sde_class_packer.sv
// ---------------------------------------------------------------------------
// cl_sde_class_packer
// Packs CNN class results (RES_W bits each) into 512-bit SDE output beats,
// RES_PER_BEAT results per beat, and frames them into packets of PKT_RES
// results. A partially filled buffer is flushed as a packet end after
// IDLE_TO idle cycles so results never get stuck.
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   res_valid/res_data/res_ready - input result stream
//   ots_valid/ots_data/ots_keep/ots_user/ots_last/ots_ready
//                             - output AXI-Stream; ots_user = {seq, beat, 0, slots}
//   pkt_cnt                   - packets completed (last beat accepted)
// ---------------------------------------------------------------------------
module cl_sde_class_packer
    import cl_sde_pkg::*;
#(
    parameter int RES_W        = SDE_CLASS_W,
    parameter int RES_PER_BEAT = 3,
    parameter int PKT_RES      = 16,
    parameter int IDLE_TO      = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      res_valid,
    input  logic [RES_W-1:0]          res_data,
    output logic                      res_ready,
    output logic                      ots_valid,
    output logic [SDE_OTS_W-1:0]      ots_data,
    output logic [SDE_OTS_KEEP_W-1:0] ots_keep,
    output logic [63:0]               ots_user,
    output logic                      ots_last,
    input  logic                      ots_ready,
    output logic [31:0]               pkt_cnt
);

    localparam int          SLOT_W    = $clog2(RES_PER_BEAT + 1);
    localparam int          RCNT_W    = $clog2(PKT_RES + 1);
    localparam int          ACC_W     = RES_PER_BEAT * RES_W;
    localparam int unsigned RES_BYTES = RES_W / 8;

    localparam logic [SLOT_W-1:0] SLOT_FULL = SLOT_W'(RES_PER_BEAT);
    localparam logic [RCNT_W-1:0] RCNT_FULL = RCNT_W'(PKT_RES);

    // Staging buffer
    logic [ACC_W-1:0]  acc;
    logic [SLOT_W-1:0] slot;
    logic              acc_done;
    logic              acc_last;
    logic [RCNT_W-1:0] rcnt;
    logic              run;

    // Packet framing
    logic [15:0]   beat_idx;
    logic [31:0]   seq_num;
    logic [15:0]   beat_idx_nxt;
    logic [31:0]   seq_nxt;
    sde_ots_user_t user_next;

    logic              accept;
    logic              out_accept;
    logic              move;
    logic              idle_expire;
    logic [SLOT_W-1:0] slot_inc;
    logic [RCNT_W-1:0] rcnt_inc;

    // NOTE: res_ready comes from a flop released one edge after reset so the
    // upstream never sees ready during the reset-release edge.
    assign res_ready  = run && !acc_done;
    assign accept     = res_valid && res_ready;
    assign out_accept = ots_valid && ots_ready;
    assign move       = acc_done && (!ots_valid || ots_ready);
    assign slot_inc   = slot + 1'b1;
    assign rcnt_inc   = rcnt + 1'b1;

    cl_sde_idle_timer #(
        .IDLE_TO (IDLE_TO)
    ) u_idle_timer (
        .clk    (clk),
        .rst    (rst),
        .en     ((slot != '0) && !acc_done && !accept),
        .clr    (accept || (slot == '0)),
        .expire (idle_expire)
    );

    // The beat loaded by a move must carry the framing that applies after a
    // beat accepted on the same edge, hence the look-ahead values.
    always_comb begin
        // NOTE: every always_comb output gets a default first; a missed branch
        // would otherwise infer a latch.
        beat_idx_nxt = beat_idx;
        seq_nxt      = seq_num;
        if (out_accept) begin
            if (ots_last) begin
                beat_idx_nxt = '0;
                seq_nxt      = seq_num + 32'd1;
            end else begin
                beat_idx_nxt = beat_idx + 16'd1;
            end
        end
        user_next.seq   = seq_nxt;
        user_next.beat  = beat_idx_nxt;
        user_next.rsvd  = '0;
        user_next.slots = 2'(slot);
    end

    // Staging buffer. accept requires !acc_done and move requires acc_done, so
    // the two never coincide; the idle flush only fires on a non-accept cycle.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the staging data is reset too, so a mid-operation reset
        // discards staged results instead of leaking them into a later beat.
        if (rst) begin
            run      <= 1'b0;
            acc      <= '0;
            slot     <= '0;
            acc_done <= 1'b0;
            acc_last <= 1'b0;
            rcnt     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every flop samples pre-edge values regardless of block order.
            run <= 1'b1;
            if (move) begin
                acc      <= '0;
                slot     <= '0;
                acc_done <= 1'b0;
                acc_last <= 1'b0;
            end else if (accept) begin
                for (int k = 0; k < RES_PER_BEAT; k++) begin
                    if (slot == SLOT_W'(k)) begin
                        acc[k*RES_W +: RES_W] <= res_data;
                    end
                end
                slot <= slot_inc;
                if (rcnt_inc == RCNT_FULL) begin
                    acc_done <= 1'b1;
                    acc_last <= 1'b1;
                    rcnt     <= '0;
                end else begin
                    rcnt <= rcnt_inc;
                    if (slot_inc == SLOT_FULL) begin
                        acc_done <= 1'b1;
                    end
                end
            end else if (idle_expire) begin
                // Forced packet end for a stalled partial buffer
                acc_done <= 1'b1;
                acc_last <= 1'b1;
                rcnt     <= '0;
            end
        end
    end

    // Output register and packet counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ots_valid <= 1'b0;
            ots_data  <= '0;
            ots_keep  <= '0;
            ots_user  <= '0;
            ots_last  <= 1'b0;
            beat_idx  <= '0;
            seq_num   <= '0;
            pkt_cnt   <= '0;
        end else begin
            if (move) begin
                ots_valid <= 1'b1;
                ots_data  <= SDE_OTS_W'(acc);
                ots_keep  <= sde_keep_mask(32'(slot), RES_BYTES);
                ots_user  <= user_next;
                ots_last  <= acc_last;
            end else if (out_accept) begin
                ots_valid <= 1'b0;
            end
            beat_idx <= beat_idx_nxt;
            seq_num  <= seq_nxt;
            if (out_accept && ots_last) begin
                pkt_cnt <= pkt_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_cl_sde_class_packer.sv
// ---------------------------------------------------------------------------
// tb_cl_sde_class_packer
// Directed bench: a table of single-beat scenarios followed by hand-written
// sequences for timeout races, mid-operation reset, back-pressure and a full
// 16-result packet. Instantiated with IDLE_TO=8 to keep timeouts short.
// ---------------------------------------------------------------------------
module tb_cl_sde_class_packer;

    localparam int RES_W = 160;
    localparam int RPB   = 3;
    localparam int PKT   = 16;
    localparam int ITO   = 8;

    localparam logic [63:0] K60 = 64'h0FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] K40 = 64'h0000_00FF_FFFF_FFFF;
    localparam logic [63:0] K20 = 64'h0000_0000_000F_FFFF;

    logic             clk = 1'b0;
    logic             rst;
    logic             res_valid;
    logic [RES_W-1:0] res_data;
    logic             res_ready;
    logic             ots_valid;
    logic [511:0]     ots_data;
    logic [63:0]      ots_keep;
    logic [63:0]      ots_user;
    logic             ots_last;
    logic             ots_ready;
    logic [31:0]      pkt_cnt;

    always #5 clk = ~clk;

    cl_sde_class_packer #(
        .RES_W        (RES_W),
        .RES_PER_BEAT (RPB),
        .PKT_RES      (PKT),
        .IDLE_TO      (ITO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .ots_valid (ots_valid),
        .ots_data  (ots_data),
        .ots_keep  (ots_keep),
        .ots_user  (ots_user),
        .ots_last  (ots_last),
        .ots_ready (ots_ready),
        .pkt_cnt   (pkt_cnt)
    );

    typedef struct {
        logic [511:0] data;
        logic [63:0]  keep;
        logic [63:0]  user;
        logic         last;
    } beat_t;

    typedef struct {
        int          nres;
        int          base;
        logic [63:0] keep;
        int          idx;
        int          seq;
        logic        last;
        int          lat;
    } row_t;

    int    n_pass  = 0;
    int    n_total = 0;
    beat_t q[$];

    // Handshake completes on the following rising edge; inputs are stable here.
    always @(negedge clk) begin
        if (ots_valid && ots_ready) begin
            q.push_back('{ots_data, ots_keep, ots_user, ots_last});
        end
    end

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [RES_W-1:0] make_res(input int tag);
        logic [31:0] t;
        t = 32'hC0DE_0000 + 32'(tag);
        return {5{t}};
    endfunction

    function automatic logic [511:0] pack(input int base, input int n);
        logic [511:0] p;
        p = '0;
        for (int k = 0; k < n; k++) p[k*RES_W +: RES_W] = make_res(base + k);
        return p;
    endfunction

    task automatic check_beat(input string nm, input beat_t b, input int base, input int n,
                              input logic [63:0] keep, input int idx, input int seq,
                              input logic last);
        logic [63:0] u;
        u = {32'(seq), 16'(idx), 14'd0, 2'(n)};
        check($sformatf("%s_data", nm), b.data, pack(base, n));
        check($sformatf("%s_keep", nm), 512'(b.keep), 512'(keep));
        check($sformatf("%s_user", nm), 512'(b.user), 512'(u));
        check($sformatf("%s_last", nm), 512'(b.last), 512'(last));
    endtask

    // Called at posedge+1; returns at posedge+1 after the last accept edge.
    task automatic send(input int base, input int n);
        int guard;
        for (int i = 0; i < n; i++) begin
            guard     = 0;
            res_valid = 1'b1;
            res_data  = make_res(base + i);
            @(negedge clk);
            while (!res_ready && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 100) check("send_timeout", 512'(guard), 512'(0));
            @(posedge clk);
            #1;
        end
        res_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!ots_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // One cycle of continuous stimulus for the back-pressure sequence.
    task automatic bp_cycle(inout int sent, inout int hold_err, inout bit snapped,
                            inout beat_t snap);
        logic acc_now;
        res_valid = (sent < 9);
        res_data  = make_res(900 + sent);
        @(negedge clk);
        acc_now = res_valid && res_ready;
        if (ots_valid) begin
            if (!snapped) begin
                snap    = '{ots_data, ots_keep, ots_user, ots_last};
                snapped = 1'b1;
            end else if (!ots_ready && (ots_data !== snap.data || ots_keep !== snap.keep ||
                                        ots_user !== snap.user || ots_last !== snap.last)) begin
                hold_err++;
            end
        end
        @(posedge clk);
        #1;
        if (acc_now) sent++;
    endtask

    initial begin
        row_t  rows[5];
        beat_t b;
        beat_t snap;
        bit    snapped;
        int    lat;
        int    sent;
        int    hold_err;
        int    guard;

        rows[0] = '{3, 100, K60, 0, 0, 1'b0, 1};
        rows[1] = '{2, 200, K40, 1, 0, 1'b1, 9};
        rows[2] = '{1, 300, K20, 0, 1, 1'b1, 9};
        rows[3] = '{3, 400, K60, 0, 2, 1'b0, 1};
        rows[4] = '{3, 500, K60, 1, 2, 1'b0, 1};

        rst       = 1'b1;
        res_valid = 1'b0;
        res_data  = '0;
        ots_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ots_valid", 512'(ots_valid), 512'(0));
        check("rst_res_ready", 512'(res_ready), 512'(0));
        check("rst_pkt_cnt", 512'(pkt_cnt), 512'(0));
        check("rst_ots_data", ots_data, 512'(0));
        check("rst_ots_user", 512'(ots_user), 512'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_release", 512'(res_ready), 512'(1));

        // Single-beat scenarios: full beats and idle-timeout flushes
        foreach (rows[r]) begin
            send(rows[r].base, rows[r].nres);
            wait_valid(lat);
            check($sformatf("row%0d_latency", r), 512'(lat), 512'(rows[r].lat));
            b = '{ots_data, ots_keep, ots_user, ots_last};
            check_beat($sformatf("row%0d", r), b, rows[r].base, rows[r].nres,
                       rows[r].keep, rows[r].idx, rows[r].seq, rows[r].last);
            @(posedge clk);
            #1;
            check($sformatf("row%0d_valid_drop", r), 512'(ots_valid), 512'(0));
        end
        check("table_pkt_cnt", 512'(pkt_cnt), 512'(2));

        // Accept in the cycle the idle counter sits at IDLE_TO-1: no flush
        send(600, 1);
        repeat (ITO - 1) begin
            @(posedge clk);
            #1;
        end
        send(601, 2);
        wait_valid(lat);
        check("race_latency", 512'(lat), 512'(1));
        b = '{ots_data, ots_keep, ots_user, ots_last};
        check_beat("race", b, 600, 3, K60, 2, 2, 1'b0);
        @(posedge clk);
        #1;

        // Mid-operation reset with a held beat and a partial buffer
        ots_ready = 1'b0;
        send(700, 3);
        send(703, 1);
        check("pre_rst_valid", 512'(ots_valid), 512'(1));
        #2;
        rst = 1'b1;
        #1;
        check("midrst_ots_valid", 512'(ots_valid), 512'(0));
        check("midrst_res_ready", 512'(res_ready), 512'(0));
        check("midrst_pkt_cnt", 512'(pkt_cnt), 512'(0));
        check("midrst_ots_user", 512'(ots_user), 512'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        ots_ready = 1'b1;
        send(800, 3);
        wait_valid(lat);
        check("postrst_latency", 512'(lat), 512'(1));
        b = '{ots_data, ots_keep, ots_user, ots_last};
        check_beat("postrst", b, 800, 3, K60, 0, 0, 1'b0);
        check("postrst_pkt_cnt", 512'(pkt_cnt), 512'(0));
        @(posedge clk);
        #1;

        // Back-pressure: output held, input stalls after two beats' worth
        q.delete();
        ots_ready = 1'b0;
        sent      = 0;
        hold_err  = 0;
        snapped   = 1'b0;
        snap      = '{'0, '0, '0, 1'b0};
        for (int c = 0; c < 20; c++) bp_cycle(sent, hold_err, snapped, snap);
        check("bp_accepted", 512'(sent), 512'(6));
        check("bp_res_ready", 512'(res_ready), 512'(0));
        check("bp_hold_stable", 512'(hold_err), 512'(0));
        check("bp_hold_data", snap.data, pack(900, 3));
        ots_ready = 1'b1;
        guard     = 0;
        while (sent < 9 && guard < 60) begin
            bp_cycle(sent, hold_err, snapped, snap);
            guard++;
        end
        res_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("bp_beats", 512'(q.size()), 512'(3));
        for (int i = 0; i < 3 && i < q.size(); i++) begin
            check_beat($sformatf("bp%0d", i), q[i], 900 + 3 * i, 3, K60, 1 + i, 0, 1'b0);
        end

        // Full 16-result packet from a clean state
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        q.delete();
        send(1000, 16);
        repeat (15) @(posedge clk);
        #1;
        check("pkt_beats", 512'(q.size()), 512'(6));
        for (int i = 0; i < 6 && i < q.size(); i++) begin
            check_beat($sformatf("pkt%0d", i), q[i], 1000 + 3 * i, (i < 5) ? 3 : 1,
                       (i < 5) ? K60 : K20, i, 0, (i == 5));
        end
        check("pkt_cnt_after", 512'(pkt_cnt), 512'(1));

        // Next packet starts at beat 0 with the next sequence number
        q.delete();
        send(1100, 3);
        repeat (5) @(posedge clk);
        #1;
        check("next_pkt_beats", 512'(q.size()), 512'(1));
        if (q.size() > 0) check_beat("next_pkt", q[0], 1100, 3, K60, 0, 1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
